// File: rtl/dram_pkg.sv
// Shared DRAM command-state type, default JEDEC timing and
// the lookup from a timed command state to its cycle count.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ACTIVATE,
    BANK_ACTIVE,
    READ,
    WRITE,
    PRECHARGE,
    REFRESH
  } dram_state_t;

  localparam int unsigned DEF_T_RCD  = 14;
  localparam int unsigned DEF_T_RL   = 22;
  localparam int unsigned DEF_T_WR   = 30;
  localparam int unsigned DEF_T_RP   = 14;
  localparam int unsigned DEF_T_RFC  = 350;
  localparam int unsigned DEF_T_REFI = 7800;

  function automatic logic isTimed(dram_state_t s);
    return s inside {ACTIVATE, READ, WRITE, PRECHARGE, REFRESH};
  endfunction

  function automatic int unsigned stateCycles(
    dram_state_t s,
    int unsigned rcd,
    int unsigned rl,
    int unsigned wr,
    int unsigned rp,
    int unsigned rfc
  );
    case (s)
      ACTIVATE:  return rcd;
      READ:      return rl;
      WRITE:     return wr;
      PRECHARGE: return rp;
      REFRESH:   return rfc;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/dram_timing_ctrl_refresh_interval_ctr.sv
// Refresh interval counter: raises a sticky refresh request
// every T_REFI cycles once init is done.
module refresh_interval_ctr
  import dram_pkg::*;
#(
  parameter int unsigned T_REFI = DEF_T_REFI,
  parameter int          CNT_W  = $clog2(T_REFI + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic initDone,
  input  logic refEntry,
  output logic rfReq
);

  logic [CNT_W-1:0] refCnt;
  logic             wrap;

  assign wrap = refCnt == CNT_W'(T_REFI - 1);

  // The entry cycle itself counts as interval cycle 0
  always_ff @(posedge CLK) begin
    if (RST || !initDone) begin
      refCnt <= '0;
      rfReq  <= 1'b0;
    end else if (refEntry) begin
      refCnt <= CNT_W'(1);
      rfReq  <= 1'b0;
    end else if (wrap) begin
      refCnt <= '0;
      rfReq  <= 1'b1;
    end else begin
      refCnt <= refCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dram_timing_ctrl.sv
// Timing stage beside the DRAM command FSM: counts JEDEC
// delays per command and returns one-cycle done strobes.
module dram_timing_ctrl
  import dram_pkg::*;
#(
  parameter int unsigned T_RCD  = DEF_T_RCD,
  parameter int unsigned T_RL   = DEF_T_RL,
  parameter int unsigned T_WR   = DEF_T_WR,
  parameter int unsigned T_RP   = DEF_T_RP,
  parameter int unsigned T_RFC  = DEF_T_RFC,
  parameter int unsigned T_REFI = DEF_T_REFI,
  parameter int          CNT_W  = $clog2(T_REFI + 1)
) (
  input  logic        CLK,
  input  logic        RST,
  input  dram_state_t cmd_state,
  input  logic        init_done,
  output logic        tACT_done,
  output logic        tRD_done,
  output logic        tWR_done,
  output logic        tPRE_done,
  output logic        tREF_done,
  output logic        rf_req
);

  dram_state_t      prevState;
  logic [CNT_W-1:0] cmdCnt;
  logic [CNT_W-1:0] cntLoad;
  logic [4:0]       doneNext;
  logic [4:0]       doneQ;
  logic             changed;
  logic             entry;
  logic             expire;

  // Counter holds cycles remaining until the done edge
  always_comb begin
    changed  = cmd_state != prevState;
    entry    = changed && isTimed(cmd_state);
    cntLoad  = CNT_W'(stateCycles(cmd_state, T_RCD, T_RL,
                                  T_WR, T_RP, T_RFC) - 1);
    expire   = !changed && cmdCnt == CNT_W'(1);
    doneNext = '0;
    if ((entry && cntLoad == '0) || expire) begin
      case (cmd_state)
        ACTIVATE:  doneNext = 5'b10000;
        READ:      doneNext = 5'b01000;
        WRITE:     doneNext = 5'b00100;
        PRECHARGE: doneNext = 5'b00010;
        REFRESH:   doneNext = 5'b00001;
        default:   doneNext = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prevState <= IDLE;
      cmdCnt    <= '0;
      doneQ     <= '0;
    end else begin
      prevState <= cmd_state;
      doneQ     <= doneNext;
      if (entry) begin
        cmdCnt <= cntLoad;
      end else if (changed) begin
        cmdCnt <= '0;
      end else if (cmdCnt != '0) begin
        cmdCnt <= cmdCnt - CNT_W'(1);
      end
    end
  end

  assign {tACT_done, tRD_done, tWR_done,
          tPRE_done, tREF_done} = doneQ;

  refresh_interval_ctr #(
    .T_REFI (T_REFI),
    .CNT_W  (CNT_W)
  ) uRefCtr (
    .CLK      (CLK),
    .RST      (RST),
    .initDone (init_done),
    .refEntry (entry && cmd_state == REFRESH),
    .rfReq    (rf_req)
  );

endmodule
